// File: rtl/rotate_gen.sv
// rotate_gen: parametrised walking-pattern generator.
// Advances a WIDTH-bit pattern one position every DIV enabled clocks.
// The pattern can rotate, shift with zero fill, or bounce between the two ends.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   en       - advance enable (low freezes prescaler and pattern)
//   load     - parallel load strobe, captures load_val and dir
//   load_val - value loaded into the pattern
//   dir      - 0 = toward MSB (left), 1 = toward LSB (right)
//   mode     - 00 rotate, 01 shift zero-fill, 10 bounce, 11 hold
//   out      - current pattern (registered)
//   step     - registered one-cycle pulse following each stepping tick
module rotate_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1,
  parameter int unsigned INIT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             step
);

  localparam int unsigned    PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] OUT_RST = WIDTH'(INIT);

  typedef enum logic {
    BDIR_LEFT  = 1'b0,
    BDIR_RIGHT = 1'b1
  } bdir_t;

  logic [WIDTH-1:0] r_out;
  logic [PW-1:0]    r_presc;
  logic             r_step;
  bdir_t            r_bdir;

  logic [WIDTH-1:0] w_out_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_step_nxt;
  bdir_t            w_bdir_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;

  // Candidate next patterns for every move
  assign w_rol  = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
  assign w_ror  = {r_out[0], r_out[WIDTH-1:1]};
  assign w_shl  = {r_out[WIDTH-2:0], 1'b0};
  assign w_shr  = {1'b0, r_out[WIDTH-1:1]};
  assign w_tick = en && (r_presc == PRESC_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= OUT_RST;
      r_presc <= '0;
      r_step  <= 1'b0;
      r_bdir  <= BDIR_LEFT;
    end else begin
      r_out   <= w_out_nxt;
      r_presc <= w_presc_nxt;
      r_step  <= w_step_nxt;
      r_bdir  <= w_bdir_nxt;
    end
  end

  // Next-state: load beats a tick; hold mode still runs the prescaler
  always_comb begin
    w_out_nxt   = r_out;
    w_presc_nxt = r_presc;
    w_bdir_nxt  = r_bdir;
    w_step_nxt  = 1'b0;
    if (load) begin
      w_out_nxt   = load_val;
      w_presc_nxt = '0;
      w_bdir_nxt  = dir ? BDIR_RIGHT : BDIR_LEFT;
    end else if (en) begin
      w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        case (mode)
          2'b00: begin
            w_out_nxt  = dir ? w_ror : w_rol;
            w_step_nxt = 1'b1;
          end
          2'b01: begin
            w_out_nxt  = dir ? w_shr : w_shl;
            w_step_nxt = 1'b1;
          end
          2'b10: begin
            // Turn around when the lit bit reaches the end we are heading to
            if (r_bdir == BDIR_LEFT) begin
              if (r_out[WIDTH-1]) begin
                w_bdir_nxt = BDIR_RIGHT;
                w_out_nxt  = w_ror;
              end else begin
                w_out_nxt  = w_rol;
              end
            end else begin
              if (r_out[0]) begin
                w_bdir_nxt = BDIR_LEFT;
                w_out_nxt  = w_rol;
              end else begin
                w_out_nxt  = w_ror;
              end
            end
            w_step_nxt = 1'b1;
          end
          default: begin
            w_out_nxt  = r_out;
            w_step_nxt = 1'b0;
          end
        endcase
      end
    end
  end

  assign out  = r_out;
  assign step = r_step;

endmodule

// File: tb/tb_rotate_gen.sv
// tb_rotate_gen: drives three rotate_gen configurations from shared stimulus
// (4-bit/DIV=1, 4-bit/DIV=3, 8-bit/DIV=2 INIT=8'h81) and compares each cycle
// with an arithmetic reference model, plus directed scenario checks.
module tb_rotate_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] lv;
  logic       dir;
  logic [1:0] mode;

  logic [3:0] o0;
  logic [3:0] o1;
  logic [7:0] o2;
  logic       s0;
  logic       s1;
  logic       s2;

  int n_total;
  int n_bad;

  int unsigned m_out  [3];
  int unsigned m_cnt  [3];
  int unsigned m_bdir [3];
  int unsigned m_step [3];

  rotate_gen #(.WIDTH(4), .DIV(1), .INIT(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[3:0]),
    .dir(dir), .mode(mode), .out(o0), .step(s0));
  rotate_gen #(.WIDTH(4), .DIV(3), .INIT(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[3:0]),
    .dir(dir), .mode(mode), .out(o1), .step(s1));
  rotate_gen #(.WIDTH(8), .DIV(2), .INIT(32'h81)) u2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv),
    .dir(dir), .mode(mode), .out(o2), .step(s2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned cfg_w(input int k);
    return (k == 2) ? 8 : 4;
  endfunction
  function automatic int unsigned cfg_div(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction
  function automatic int unsigned cfg_init(input int k);
    return (k == 2) ? 32'h81 : 1;
  endfunction
  function automatic int unsigned msk(input int unsigned w);
    return (1 << w) - 1;
  endfunction
  function automatic int unsigned rol(input int unsigned x, input int unsigned w);
    return ((x << 1) | (x >> (w - 1))) & msk(w);
  endfunction
  function automatic int unsigned ror(input int unsigned x, input int unsigned w);
    return ((x >> 1) | ((x & 1) << (w - 1))) & msk(w);
  endfunction

  function automatic int unsigned obs_out(input int k);
    case (k)
      0:       return 32'(o0);
      1:       return 32'(o1);
      default: return 32'(o2);
    endcase
  endfunction
  function automatic int unsigned obs_step(input int k);
    case (k)
      0:       return 32'(s0);
      1:       return 32'(s1);
      default: return 32'(s2);
    endcase
  endfunction

  // Reference behaviour for one configuration at one clock edge
  task automatic model_upd(input int k);
    int unsigned w;
    int unsigned x;
    w = cfg_w(k);
    x = m_out[k];
    m_step[k] = 0;
    if (rst) begin
      m_out[k]  = cfg_init(k) & msk(w);
      m_cnt[k]  = 0;
      m_bdir[k] = 0;
    end else if (load) begin
      m_out[k]  = 32'(lv) & msk(w);
      m_cnt[k]  = 0;
      m_bdir[k] = 32'(dir);
    end else if (en) begin
      if (m_cnt[k] == cfg_div(k) - 1) begin
        m_cnt[k] = 0;
        if (mode != 2'b11) m_step[k] = 1;
        case (mode)
          2'b00: m_out[k] = dir ? ror(x, w) : rol(x, w);
          2'b01: m_out[k] = dir ? (x >> 1) : ((x << 1) & msk(w));
          2'b10: begin
            if (m_bdir[k] == 0) begin
              if (((x >> (w - 1)) & 1) == 1) begin
                m_bdir[k] = 1;
                m_out[k]  = ror(x, w);
              end else begin
                m_out[k]  = rol(x, w);
              end
            end else begin
              if ((x & 1) == 1) begin
                m_bdir[k] = 0;
                m_out[k]  = rol(x, w);
              end else begin
                m_out[k]  = ror(x, w);
              end
            end
          end
          default: m_out[k] = x;
        endcase
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  // One clock: update model at the edge, then compare away from the edge
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_upd(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_out_u%0d", k), obs_out(k), m_out[k]);
      check($sformatf("model_step_u%0d", k), obs_step(k), m_step[k]);
    end
  endtask

  int unsigned seq1 [4];
  int unsigned seq3 [4];
  int unsigned seq4 [7];
  int          nstep;

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int k = 0; k < 3; k++) begin
      m_out[k] = 0; m_cnt[k] = 0; m_bdir[k] = 0; m_step[k] = 0;
    end
    seq1 = '{4'h2, 4'h4, 4'h8, 4'h1};
    seq3 = '{4'hC, 4'h8, 4'h0, 4'h0};
    seq4 = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

    rst = 1'b1; en = 1'b0; load = 1'b0; lv = 8'h00; dir = 1'b0; mode = 2'b00;
    #2;
    cycle();
    check("rst_out_u0", 32'(o0), 1);
    check("rst_out_u2", 32'(o2), 32'h81);
    check("rst_step_u0", 32'(s0), 0);

    // Rotate left; 8-bit/DIV=2 wraps after 16 enabled cycles
    rst = 1'b0; en = 1'b1;
    nstep = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i < 4) begin
        check("rotl_out_u0", 32'(o0), seq1[i]);
        check("rotl_step_u0", 32'(s0), 1);
      end
      if (s2) nstep++;
    end
    check("wrap_out_u2", 32'(o2), 32'h81);
    check("wrap_steps_u2", 32'(nstep), 8);
    check("wrap_out_u0", 32'(o0), 1);

    // DIV=3 rotate right, then freeze prescaler with en low
    rst = 1'b1; cycle();
    rst = 1'b0; dir = 1'b1;
    cycle(); cycle();
    check("div3_nostep_u1", 32'(s1), 0);
    cycle();
    check("div3_out1_u1", 32'(o1), 4'h8);
    check("div3_step_u1", 32'(s1), 1);
    cycle(); cycle(); cycle();
    check("div3_out2_u1", 32'(o1), 4'h4);
    cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("freeze_out_u1", 32'(o1), 4'h4);
      check("freeze_step_u1", 32'(s1), 0);
    end
    en = 1'b1;
    cycle();
    check("resume_hold_u1", 32'(o1), 4'h4);
    cycle();
    check("resume_out_u1", 32'(o1), 4'h2);
    check("resume_step_u1", 32'(s1), 1);

    // Shift left zero-fill from 0110
    load = 1'b1; lv = 8'h06; mode = 2'b01; dir = 1'b0;
    cycle();
    check("shl_load_u0", 32'(o0), 4'h6);
    check("shl_load_step_u0", 32'(s0), 0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("shl_out_u0", 32'(o0), seq3[i]);
      check("shl_step_u0", 32'(s0), 1);
    end

    // Bounce from 0001 heading left
    load = 1'b1; lv = 8'h01; mode = 2'b10; dir = 1'b0;
    cycle();
    load = 1'b0; dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("bounce_out_u0", 32'(o0), seq4[i]);
    end

    // rst beats load; load beats a tick
    rst = 1'b1; load = 1'b1; lv = 8'h0A; mode = 2'b00;
    cycle();
    check("rst_over_load_u0", 32'(o0), 1);
    rst = 1'b0;
    cycle();
    check("load_over_tick_u0", 32'(o0), 4'hA);
    check("load_over_tick_step_u0", 32'(s0), 0);
    load = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      lv   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) lv = 8'(1 << $urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
